vga_palette_ctrl: RTL and testbench
===================================

// Module: vga_palette_ctrl
// PURPOSE
//  Sequences the 3-bit palette path of the display: VGA 640x480 timing, cell-RAM fetch, overlay selection.
//  Produces per-pixel color_idx for the palette decoder (index->24-bit RGB), pipelined with hsync/vsync.
//  Selection priority: blanking > grid > cursor > cell. Screen is a COLS x ROWS grid of square cells.
// PARAMETERS
//  H_ACTIVE 640 | H_FP 16 | H_SYNC 96 | H_BP 48 : horizontal timing, pixels (H_TOTAL=800)
//  V_ACTIVE 480 | V_FP 10 | V_SYNC 2  | V_BP 33 : vertical timing, lines (V_TOTAL=525)
//  CELL_SHIFT 5 : cell size 2**CELL_SHIFT px; COLS=H_ACTIVE>>CELL_SHIFT=20, ROWS=V_ACTIVE>>CELL_SHIFT=15
//  ADDR_W 9     : cell RAM address width (>= clog2(COLS*ROWS))
//  GRID_EN 1    : 1 = draw cell borders in index 1 (black)
//  BLINK_BIT 4  : frame-counter bit gating cursor blink
// PORTS
//  clk          in  1      system clock
//  rst          in  1      synchronous reset, active high
//  pix_en       in  1      pixel strobe; all pipeline/counter state advances only when 1
//  cell_addr    out ADDR_W row*COLS+col of current pixel, registered
//  cell_data    in  3      cell RAM read data, valid 1 clk after cell_addr changes
//  cursor_col   in  5      cursor cell column
//  cursor_row   in  4      cursor cell row
//  cursor_color in  3      palette index for cursor
//  color_idx    out 3      palette index to decoder
//  hsync        out 1      horizontal sync, active low
//  vsync        out 1      vertical sync, active low
//  active       out 1      1 = color_idx is a visible pixel
//  frame_start  out 1      1-clk pulse at counter wrap to (0,0)
// BEHAVIOUR
//  Reset (clk edge with rst=1, overrides pix_en): h_cnt=v_cnt=0, frame_cnt=0, cell_addr=0, color_idx=3'd1,
//   hsync=1, vsync=1, active=0, frame_start=0, cursor latches=0, all pipeline valid/sync bits cleared to idle.
//  pix_en=0: every register holds; frame_start forced 0.
//  Stage 0 (counters): h_cnt 0..H_TOTAL-1; at H_TOTAL-1 wraps to 0 and v_cnt increments;
//   v_cnt wraps V_TOTAL-1 -> 0. On (799,524)->(0,0): frame_start=1 for that clk, frame_cnt+=1 (5 bit, wraps),
//   cursor_col/row/color latched (cursor changes take effect at frame boundary only, no tearing).
//  Stage 1 (tick after counter value): cell_addr=(v>>CELL_SHIFT)*COLS+(h>>CELL_SHIFT) when visible, else 0;
//   register vis1=(h<H_ACTIVE && v<V_ACTIVE), hs1=!(H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC),
//   vs1 likewise on v, grid1=GRID_EN && (h[CELL_SHIFT-1:0]==0 || v[CELL_SHIFT-1:0]==0),
//   cur1=(col==latched col && row==latched row && frame_cnt[BLINK_BIT]==0).
//  Stage 2 (next tick): cell_data sampled; color_idx = !vis1 ? 1 : grid1 ? 1 : cur1 ? cursor_color_l : cell_data;
//   hsync=hs1, vsync=vs1, active=vis1.
//  Latency: counter value (h,v) appears on color_idx/hsync/vsync/active exactly 2 pix_en ticks later;
//   sync and color stay aligned for any pix_en duty cycle.
//  Cursor latched out of range (col>=COLS or row>=ROWS): never drawn, no error.
//  Multiplier COLS constant: implement as shifts/adds; no truncation within ADDR_W.
//  rst mid-line/mid-frame: next edge returns to reset state; restart from (0,0) with no partial sync pulse.
// TESTING
//  1 rst 2 clks, pix_en=1: hsync low exactly 96 ticks every 800; vsync low 1600 ticks every 420000;
//    first hsync fall 658 ticks after rst release.
//  2 RAM model data=addr[2:0], GRID_EN=0, no cursor: pixel (h=70,v=70) -> cell_addr=42, color_idx=2, active=1.
//  3 Defaults: pixels (64,70) and (70,96) -> color_idx=1; pixel (700,70) -> color_idx=1, active=0.
//  4 Cursor (3,2) color 5: pixel (100,70) = 5 in frames 0-15, = cell_data(43&7=3) in frames 16-31.
//  5 Change cursor to (4,2) mid-frame: old position still drawn rest of frame; new from next frame_start.
//  6 pix_en every 2nd clk, rst at h=300,v=200: next clk reset values; hsync period 1600 clks after resume.

Source files
------------

// File: rtl/vga_palette_ctrl.sv
// vga_palette_ctrl: VGA raster timing, cell-RAM address generation and
// overlay selection for the 3-bit palette path. The counter state (stage 0),
// the decoded per-pixel flags (stage 1) and the final palette index (stage 2)
// advance only on pix_en, so sync and color stay aligned at any strobe rate.
module vga_palette_ctrl #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int CELL_SHIFT = 5,
  parameter int ADDR_W     = 9,
  parameter int GRID_EN    = 1,
  parameter int BLINK_BIT  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_en,
  output logic [ADDR_W-1:0] cell_addr,
  input  logic [2:0]        cell_data,
  input  logic [4:0]        cursor_col,
  input  logic [3:0]        cursor_row,
  input  logic [2:0]        cursor_color,
  output logic [2:0]        color_idx,
  output logic              hsync,
  output logic              vsync,
  output logic              active,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int COLS    = H_ACTIVE >> CELL_SHIFT;
  localparam int H_W     = $clog2(H_TOTAL + 1);
  localparam int V_W     = $clog2(V_TOTAL + 1);

  localparam logic [H_W-1:0]    H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0]    V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [H_W-1:0]    H_VIS    = H_W'(H_ACTIVE);
  localparam logic [V_W-1:0]    V_VIS    = V_W'(V_ACTIVE);
  localparam logic [H_W-1:0]    HS_START = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0]    HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0]    VS_START = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0]    VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [ADDR_W-1:0] COLS_V   = ADDR_W'(COLS);

  // row * COLS built from shifted adds of the row, one per set bit of COLS
  function automatic logic [ADDR_W-1:0] times_cols(input logic [ADDR_W-1:0] r);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int b = 0; b < ADDR_W; b++)
      if (COLS_V[b]) acc = acc + (r << b);
    return acc;
  endfunction

  // stage 0 state
  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;
  logic [4:0]     frame_cnt;
  logic [4:0]     cur_col_l;
  logic [3:0]     cur_row_l;
  logic [2:0]     cur_color_l;

  // stage 1 state
  logic vis1, hs1, vs1, grid1, cur1;

  // stage 0 decode feeding stage 1
  logic              h_last, v_last;
  logic [H_W-1:0]    col;
  logic [V_W-1:0]    row;
  logic              vis_nxt, hs_nxt, vs_nxt, grid_nxt, cur_nxt;
  logic [ADDR_W-1:0] addr_nxt;

  assign h_last   = (h_cnt == H_LAST);
  assign v_last   = (v_cnt == V_LAST);
  assign col      = h_cnt >> CELL_SHIFT;
  assign row      = v_cnt >> CELL_SHIFT;
  assign vis_nxt  = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hs_nxt   = !((h_cnt >= HS_START) && (h_cnt < HS_END));
  assign vs_nxt   = !((v_cnt >= VS_START) && (v_cnt < VS_END));
  assign grid_nxt = (GRID_EN != 0) &&
                    ((h_cnt[CELL_SHIFT-1:0] == '0) || (v_cnt[CELL_SHIFT-1:0] == '0));
  // An out-of-range latched cursor can never equal a visible cell, so it simply never shows.
  assign cur_nxt  = (int'(col) == int'(cur_col_l)) && (int'(row) == int'(cur_row_l)) &&
                    !frame_cnt[BLINK_BIT];
  assign addr_nxt = times_cols(ADDR_W'(row)) + ADDR_W'(col);

  // stage 0: raster counters, frame counter and frame-boundary cursor latch
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_cnt   <= '0;
      cur_col_l   <= '0;
      cur_row_l   <= '0;
      cur_color_l <= '0;
      frame_start <= 1'b0;
    end else begin
      // NOTE: state updates use <= so every stage reads the pre-edge value of the stage before it.
      frame_start <= 1'b0;
      if (pix_en) begin
        if (h_last) begin
          h_cnt <= '0;
          if (v_last) begin
            v_cnt       <= '0;
            frame_cnt   <= frame_cnt + 5'd1;
            cur_col_l   <= cursor_col;
            cur_row_l   <= cursor_row;
            cur_color_l <= cursor_color;
            frame_start <= 1'b1;
          end else begin
            v_cnt <= v_cnt + V_W'(1);
          end
        end else begin
          h_cnt <= h_cnt + H_W'(1);
        end
      end
    end
  end

  // stage 1: RAM address and per-pixel flags for the current counter value
  always_ff @(posedge clk) begin
    if (rst) begin
      cell_addr <= '0;
      vis1      <= 1'b0;
      hs1       <= 1'b1;
      vs1       <= 1'b1;
      grid1     <= 1'b0;
      cur1      <= 1'b0;
    end else if (pix_en) begin
      cell_addr <= vis_nxt ? addr_nxt : '0;
      vis1      <= vis_nxt;
      hs1       <= hs_nxt;
      vs1       <= vs_nxt;
      grid1     <= grid_nxt;
      cur1      <= cur_nxt;
    end
  end

  // stage 2: overlay priority (blank > grid > cursor > cell) and sync alignment
  always_ff @(posedge clk) begin
    if (rst) begin
      color_idx <= 3'd1;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
      active    <= 1'b0;
    end else if (pix_en) begin
      if (!vis1)      color_idx <= 3'd1;
      else if (grid1) color_idx <= 3'd1;
      else if (cur1)  color_idx <= cur_color_l;
      else            color_idx <= cell_data;
      hsync  <= hs1;
      vsync  <= vs1;
      active <= vis1;
    end
  end

endmodule

// File: tb/tb_vga_palette_ctrl.sv
// tb_vga_palette_ctrl: directed bench. A full-size instance covers line timing,
// addressing, overlay priority and reset mid-frame; a shrunken instance
// (8 px cells, 40x20 raster, grid off, blink on frame bit 2) makes multi-frame
// behaviour (vsync, frame_start, cursor latching and blink) reachable quickly.
module tb_vga_palette_ctrl;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // full-size instance
  logic       rst, pix_en;
  logic [8:0] cell_addr;
  logic [2:0] cell_data;
  logic [4:0] cursor_col;
  logic [3:0] cursor_row;
  logic [2:0] cursor_color;
  logic [2:0] color_idx;
  logic       hsync, vsync, active, frame_start;

  // shrunken instance
  logic       s_rst, s_pix_en;
  logic [8:0] s_cell_addr;
  logic [2:0] s_cell_data;
  logic [4:0] s_cursor_col;
  logic [3:0] s_cursor_row;
  logic [2:0] s_cursor_color;
  logic [2:0] s_color_idx;
  logic       s_hsync, s_vsync, s_active, s_frame_start;

  // cell RAM models: data is the low 3 bits of the address, settled within the cycle
  assign cell_data   = cell_addr[2:0];
  assign s_cell_data = s_cell_addr[2:0];

  vga_palette_ctrl u_dut (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .cell_addr(cell_addr), .cell_data(cell_data),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .cursor_color(cursor_color),
    .color_idx(color_idx), .hsync(hsync), .vsync(vsync),
    .active(active), .frame_start(frame_start)
  );

  vga_palette_ctrl #(
    .H_ACTIVE(32), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(16), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CELL_SHIFT(3), .ADDR_W(9), .GRID_EN(0), .BLINK_BIT(2)
  ) u_small (
    .clk(clk), .rst(s_rst), .pix_en(s_pix_en),
    .cell_addr(s_cell_addr), .cell_data(s_cell_data),
    .cursor_col(s_cursor_col), .cursor_row(s_cursor_row), .cursor_color(s_cursor_color),
    .color_idx(s_color_idx), .hsync(s_hsync), .vsync(s_vsync),
    .active(s_active), .frame_start(s_frame_start)
  );

  int checks = 0;
  int errors = 0;
  int pos_a  = 0;   // pix_en ticks since reset release, full-size instance
  int clk_a  = 0;   // clocks since reset release in the half-rate phase
  int pos_b  = 0;   // pix_en ticks since reset release, shrunken instance
  int t      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick_a();
    pix_en = 1'b1;
    @(posedge clk); #1;
    pos_a++;
  endtask

  task automatic run_a(input int target);
    while (pos_a < target) tick_a();
  endtask

  // one strobed clock followed by one idle clock
  task automatic slow_a();
    pix_en = 1'b1;
    @(posedge clk); #1;
    pos_a++;
    clk_a++;
    pix_en = 1'b0;
    @(posedge clk); #1;
    clk_a++;
  endtask

  task automatic tick_b();
    s_pix_en = 1'b1;
    @(posedge clk); #1;
    pos_b++;
  endtask

  task automatic run_b(input int target);
    while (pos_b < target) tick_b();
  endtask

  initial begin
    rst            = 1'b1;
    pix_en         = 1'b1;
    cursor_col     = 5'd31;
    cursor_row     = 4'd15;
    cursor_color   = 3'd0;
    s_rst          = 1'b1;
    s_pix_en       = 1'b0;
    s_cursor_col   = 5'd1;
    s_cursor_row   = 4'd1;
    s_cursor_color = 3'd7;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_color", color_idx, 3'd1);
    check("rst_hsync", hsync, 1'b1);
    check("rst_vsync", vsync, 1'b1);
    check("rst_active", active, 1'b0);
    check("rst_addr", cell_addr, 9'd0);
    check("rst_fstart", frame_start, 1'b0);
    check("s_rst_color", s_color_idx, 3'd1);

    // two-tick latency from counter (0,0)
    rst = 1'b0;
    pos_a = 0;
    tick_a();
    check("pipe_idle_active", active, 1'b0);
    tick_a();
    check("pix00_active", active, 1'b1);
    check("pix00_grid", color_idx, 3'd1);

    // horizontal sync placement, width and period
    while (hsync !== 1'b0 && pos_a < 2000) tick_a();
    check("hs_first_fall", pos_a, 658);
    t = pos_a;
    while (hsync !== 1'b1 && pos_a < t + 2000) tick_a();
    check("hs_low_ticks", pos_a - t, 96);
    while (hsync !== 1'b0 && pos_a < t + 4000) tick_a();
    check("hs_period", pos_a - t, 800);

    // pixel (70,64): cell (2,2), horizontal grid line
    run_a(64*800 + 70 + 1);
    check("addr_70_64", cell_addr, 9'd42);
    run_a(64*800 + 70 + 2);
    check("grid_row", color_idx, 3'd1);

    // pixel (64,70): vertical grid line
    run_a(70*800 + 64 + 2);
    check("grid_col", color_idx, 3'd1);
    check("grid_col_active", active, 1'b1);

    // pixel (70,70): plain cell
    run_a(70*800 + 70 + 1);
    check("addr_70_70", cell_addr, 9'd42);
    run_a(70*800 + 70 + 2);
    check("cell_70_70", color_idx, 3'd2);
    check("cell_70_70_active", active, 1'b1);

    // pixel (100,70): neighbouring cell
    run_a(70*800 + 100 + 1);
    check("addr_100_70", cell_addr, 9'd43);
    run_a(70*800 + 100 + 2);
    check("cell_100_70", color_idx, 3'd3);

    // pixel (700,70): horizontal blanking inside the sync pulse
    run_a(70*800 + 700 + 1);
    check("addr_blank", cell_addr, 9'd0);
    run_a(70*800 + 700 + 2);
    check("blank_color", color_idx, 3'd1);
    check("blank_active", active, 1'b0);
    check("blank_hsync", hsync, 1'b0);

    // half-rate strobe up to counter (300,71), then reset mid-line with pix_en low
    while (pos_a < 71*800 + 300) slow_a();
    check("slow_addr_299_71", cell_addr, 9'd49);
    check("slow_active", active, 1'b1);
    rst = 1'b1;
    pix_en = 1'b0;
    @(posedge clk); #1;
    check("midrst_addr", cell_addr, 9'd0);
    check("midrst_active", active, 1'b0);
    check("midrst_color", color_idx, 3'd1);
    check("midrst_hsync", hsync, 1'b1);
    check("midrst_vsync", vsync, 1'b1);

    // restart at half rate: sync timing measured in clocks
    rst = 1'b0;
    pos_a = 0;
    clk_a = 0;
    while (hsync !== 1'b0 && clk_a < 4000) slow_a();
    check("slow_first_fall_ticks", pos_a, 658);
    t = clk_a;
    while (hsync !== 1'b1 && clk_a < t + 4000) slow_a();
    check("slow_hs_low_clks", clk_a - t, 192);
    while (hsync !== 1'b0 && clk_a < t + 8000) slow_a();
    check("slow_hs_period_clks", clk_a - t, 1600);
    pix_en = 1'b0;
    rst = 1'b1;

    // shrunken instance: 40x20 raster, 800 ticks per frame
    s_pix_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    s_rst = 1'b0;
    pos_b = 0;

    // frame 0: latched cursor is still the reset value, pixel (10,10) shows cell 5
    run_b(412);
    check("s_f0_cell", s_color_idx, 3'd5);

    // vertical sync on lines 17..18
    while (s_vsync !== 1'b0 && pos_b < 2000) tick_b();
    check("s_vs_first_fall", pos_b, 682);
    t = pos_b;
    while (s_vsync !== 1'b1 && pos_b < t + 2000) tick_b();
    check("s_vs_low_ticks", pos_b - t, 80);

    // frame_start one tick wide at the wrap
    while (s_frame_start !== 1'b1 && pos_b < 2000) tick_b();
    check("s_fstart_pos", pos_b, 800);
    tick_b();
    check("s_fstart_pulse", s_frame_start, 1'b0);

    // frame 1: cursor (1,1) color 7 latched
    run_b(800 + 412);
    check("s_f1_cursor", s_color_idx, 3'd7);
    s_cursor_col = 5'd2;
    run_b(800 + 14*40 + 10 + 2);
    check("s_f1_old_pos_held", s_color_idx, 3'd7);
    run_b(800 + 14*40 + 18 + 2);
    check("s_f1_new_pos_wait", s_color_idx, 3'd6);

    while (s_vsync !== 1'b0 && pos_b < 3000) tick_b();
    check("s_vs_period", pos_b, 1482);

    // frame 2: cursor moved to (2,1)
    run_b(1600 + 412);
    check("s_f2_old_pos_cell", s_color_idx, 3'd5);
    run_b(1600 + 420);
    check("s_f2_new_pos", s_color_idx, 3'd7);
    s_cursor_col = 5'd4;

    // frame 3: out-of-range cursor never drawn
    run_b(2400 + 412);
    check("s_f3_oob_c1", s_color_idx, 3'd5);
    run_b(2400 + 420);
    check("s_f3_oob_c2", s_color_idx, 3'd6);
    s_cursor_col = 5'd2;

    // frame 4: blink bit set, cursor hidden
    run_b(3200 + 420);
    check("s_f4_blink_off", s_color_idx, 3'd6);

    // frame 8: blink bit clear again
    run_b(6400 + 420);
    check("s_f8_blink_on", s_color_idx, 3'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
